// File: rtl/time_set_editor_pkg.sv
// time_set_editor_pkg: state/mode encodings, display codes, BCD digit limits and cursor helpers
package time_set_editor_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_EDIT, ST_COMMIT} state_t;
    localparam logic [3:0] MODE_RUN      = 4'd0;
    localparam logic [3:0] MODE_EDIT     = 4'd1;
    localparam logic [3:0] SEP_CODE      = 4'hb;
    localparam logic [3:0] BLANK_CODE    = 4'ha;
    localparam logic [4:0] CURSOR_OFF    = 5'd31;
    localparam logic [3:0] MAX_SEC1      = 4'd9;
    localparam logic [3:0] MAX_SEC10     = 4'd5;
    localparam logic [3:0] MAX_MIN1      = 4'd9;
    localparam logic [3:0] MAX_MIN10     = 4'd5;
    localparam logic [3:0] MAX_HR1       = 4'd9;
    localparam logic [3:0] MAX_HR1_AT_20 = 4'd3;
    localparam logic [3:0] MAX_HR10      = 4'd2;
    // Display positions 0,1,3,4,6,7 map onto packed BCD nibbles 0..5.
    function automatic logic [2:0] pos_idx(input logic [2:0] pos);
        return pos == 3'd7 ? 3'd5 : pos == 3'd6 ? 3'd4 : pos == 3'd4 ? 3'd3 :
               pos == 3'd3 ? 3'd2 : pos == 3'd1 ? 3'd1 : 3'd0;
    endfunction
    function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] h10);
        return idx == 3'd0 ? MAX_SEC1 : idx == 3'd1 ? MAX_SEC10 : idx == 3'd2 ? MAX_MIN1 :
               idx == 3'd3 ? MAX_MIN10 : idx == 3'd4 ? (h10 == 4'd2 ? MAX_HR1_AT_20 : MAX_HR1) : MAX_HR10;
    endfunction
    function automatic logic [2:0] pos_left(input logic [2:0] pos);
        return pos == 3'd7 ? 3'd0 : pos == 3'd1 ? 3'd3 : pos == 3'd4 ? 3'd6 : pos + 3'd1;
    endfunction
    function automatic logic [2:0] pos_right(input logic [2:0] pos);
        return pos == 3'd0 ? 3'd7 : pos == 3'd3 ? 3'd1 : pos == 3'd6 ? 3'd4 : pos - 3'd1;
    endfunction
    function automatic logic [31:0] fmt_digits(input logic [23:0] t);
        return {t[23:16], SEP_CODE, t[15:8], SEP_CODE, t[7:0]};
    endfunction
endpackage

// File: rtl/time_set_editor_if.sv
// time_set_editor_if: raw buttons and running time in, display codes and commit strobe out
interface time_set_editor_if;
    logic        btn_set, btn_left, btn_right, btn_up, btn_down;
    logic [23:0] cur_time;
    logic [31:0] digits;
    logic [4:0]  cursor;
    logic [3:0]  mode;
    logic [23:0] set_time;
    logic        load;
    modport master (
        output btn_set, btn_left, btn_right, btn_up, btn_down, cur_time,
        input  digits, cursor, mode, set_time, load
    );
    modport slave (
        input  btn_set, btn_left, btn_right, btn_up, btn_down, cur_time,
        output digits, cursor, mode, set_time, load
    );
endinterface

// File: rtl/time_set_editor_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and single-cycle press pulse
// With AUTO_REPEAT_EN defined, rep_en plus a held level re-issues the pulse every REPEAT_CYCLES.
module btn_debounce #(
`ifdef AUTO_REPEAT_EN
    parameter logic [23:0] REPEAT_CYCLES = 24'd5_000_000,
`endif
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AUTO_REPEAT_EN
    input  logic rep_en,
`endif
    input  logic btn,
    output logic press
);
    logic [1:0]  sync;
    logic        level, accept, rep_fire;
    logic [19:0] cnt;
    // cnt counts consecutive samples that disagree with the accepted level.
    assign accept = sync[1] != level && cnt == DEBOUNCE_CYCLES - 20'd1;
`ifdef AUTO_REPEAT_EN
    logic [23:0] rcnt;
    logic        held;
    assign held     = rep_en && level;
    assign rep_fire = held && rcnt == REPEAT_CYCLES - 24'd1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rcnt <= 24'd0;
        else        rcnt <= held && !rep_fire ? rcnt + 24'd1 : 24'd0;
`else
    assign rep_fire = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= 20'd0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= sync[1] == level || accept ? 20'd0 : cnt + 20'd1;
            level <= accept ? sync[1] : level;
            press <= (accept && sync[1]) || rep_fire;
        end
endmodule

// File: rtl/time_set_editor.sv
// time_set_editor: RUN/EDIT/COMMIT time-set FSM driving an 8-digit display and a commit strobe
// AUTO_REPEAT_EN enables auto-repeat of held up/down buttons while editing.
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd5_000_000
) (
    input logic              clk,
    input logic              rst_n,
    time_set_editor_if.slave bus
);
    state_t      state, state_nx;
    logic [4:0]  raw, press;
    logic        ev_set, ev_left, ev_right, ev_up, ev_dn;
    logic [23:0] et, et_nx, et_mod, set_time_q;
    logic [2:0]  pos, pos_nx, idx;
    logic [3:0]  dig, lim, dig_nx;
    logic [31:0] digits_q;

    assign raw = {bus.btn_set, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
`ifdef AUTO_REPEAT_EN
    logic [4:0] rep_en;
    assign rep_en = {3'b000, {2{state == ST_EDIT}}};
`endif
    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
`ifdef AUTO_REPEAT_EN
            .REPEAT_CYCLES(REPEAT_CYCLES),
`endif
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk(clk),
            .rst_n(rst_n),
`ifdef AUTO_REPEAT_EN
            .rep_en(rep_en[i]),
`endif
            .btn(raw[i]),
            .press(press[i])
        );
    end

    // A higher-priority pulse masks every lower one in the same cycle.
    assign ev_set   = press[4];
    assign ev_left  = press[3] && !press[4];
    assign ev_right = press[2] && !(|press[4:3]);
    assign ev_up    = press[1] && !(|press[4:2]);
    assign ev_dn    = press[0] && !(|press[4:1]);

    always_comb begin
        idx    = pos_idx(pos);
        dig    = et[{idx, 2'b00} +: 4];
        lim    = digit_max(idx, et[23:20]);
        dig_nx = ev_up ? (dig >= lim ? 4'd0 : dig + 4'd1) : (dig == 4'd0 ? lim : dig - 4'd1);
        et_mod = et;
        et_mod[{idx, 2'b00} +: 4] = dig_nx;
        if (et_mod[23:20] == 4'd2 && et_mod[19:16] > MAX_HR1_AT_20) et_mod[19:16] = MAX_HR1_AT_20;
    end

    always_comb begin
        state_nx = state == ST_RUN  ? (ev_set ? ST_EDIT : ST_RUN) :
                   state == ST_EDIT ? (ev_set ? ST_COMMIT : ST_EDIT) : ST_RUN;
        et_nx    = state == ST_RUN && ev_set ? bus.cur_time :
                   state == ST_EDIT && (ev_up || ev_dn) ? et_mod : et;
        pos_nx   = state == ST_RUN && ev_set ? 3'd0 : state != ST_EDIT ? pos :
                   ev_left ? pos_left(pos) : ev_right ? pos_right(pos) : pos;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= ST_RUN;
            et         <= 24'd0;
            pos        <= 3'd0;
            digits_q   <= fmt_digits(24'd0);
            set_time_q <= 24'd0;
        end else begin
            state      <= state_nx;
            et         <= et_nx;
            pos        <= pos_nx;
            digits_q   <= fmt_digits(state == ST_RUN ? bus.cur_time : et);
            set_time_q <= state == ST_EDIT && ev_set ? et : set_time_q;
        end

    assign bus.digits   = digits_q;
    assign bus.cursor   = state == ST_EDIT ? {2'b00, pos} : CURSOR_OFF;
    assign bus.mode     = state == ST_RUN ? MODE_RUN : MODE_EDIT;
    assign bus.set_time = set_time_q;
    assign bus.load     = state == ST_COMMIT;
endmodule

// File: tb/tb_time_set_editor.sv
// tb_time_set_editor: directed scoreboard bench for time_set_editor with a short debounce time
module tb_time_set_editor;
    localparam logic [4:0] B_SET   = 5'b10000;
    localparam logic [4:0] B_LEFT  = 5'b01000;
    localparam logic [4:0] B_RIGHT = 5'b00100;
    localparam logic [4:0] B_UP    = 5'b00010;
    localparam logic [4:0] B_DN    = 5'b00001;

    typedef struct {
        string       tag;
        logic [31:0] digits;
        logic [4:0]  cursor;
        logic [3:0]  mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   load_cnt = 0;

    always #5 clk = ~clk;

    time_set_editor_if bus();
    time_set_editor #(.DEBOUNCE_CYCLES(20'd4), .REPEAT_CYCLES(24'd50)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always @(negedge clk) if (bus.load === 1'b1) load_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {bus.btn_set, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = m;
    endtask

    task automatic press(input logic [4:0] m);
        drive(m);
        repeat (10) @(negedge clk);
        drive(5'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [4:0] c, input logic [3:0] md);
        exp_t e;
        e.tag = tag;
        e.digits = d;
        e.cursor = c;
        e.mode = md;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, ".digits"}, bus.digits, e.digits);
        chk({e.tag, ".cursor"}, 32'(bus.cursor), 32'(e.cursor));
        chk({e.tag, ".mode"}, 32'(bus.mode), 32'(e.mode));
    endtask

    task automatic step(input string tag, input logic [4:0] m, input logic [31:0] d, input logic [4:0] c, input logic [3:0] md);
        expect_out(tag, d, c, md);
        press(m);
        check_out();
    endtask

    task automatic wait_commit(input logic [23:0] exp_set);
        int n = 0;
        while (bus.load !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("commit.load_seen", 32'(bus.load), 32'd1);
        chk("commit.set_time", 32'(bus.set_time), 32'(exp_set));
        chk("commit.mode", 32'(bus.mode), 32'd1);
        chk("commit.cursor", 32'(bus.cursor), 32'd31);
        @(negedge clk);
        chk("commit.load_drop", 32'(bus.load), 32'd0);
        chk("commit.mode_run", 32'(bus.mode), 32'd0);
        chk("commit.cursor_off", 32'(bus.cursor), 32'd31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int curs[7] = '{1, 3, 4, 3, 1, 0, 7};
        automatic logic [31:0] hdn[4] = '{32'h12b59b59, 32'h11b59b59, 32'h10b59b59, 32'h19b59b59};
        drive(5'd0);
        bus.cur_time = 24'h123456;
        repeat (3) @(negedge clk);
        expect_out("reset", 32'h00b00b00, 5'd31, 4'd0);
        check_out();
        chk("reset.set_time", 32'(bus.set_time), 32'd0);
        chk("reset.load", 32'(bus.load), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_out("run_time", 32'h12b34b56, 5'd31, 4'd0);
        check_out();

        bus.cur_time = 24'h235959;
        step("enter_edit", B_SET, 32'h23b59b59, 5'd0, 4'd1);
        bus.cur_time = 24'h010203;
        step("s1_up_wrap", B_UP, 32'h23b59b50, 5'd0, 4'd1);
        step("s1_down_wrap", B_DN, 32'h23b59b59, 5'd0, 4'd1);
        for (int i = 0; i < 7; i++)
            step($sformatf("cursor_move%0d", i), i < 3 ? B_LEFT : B_RIGHT, 32'h23b59b59, 5'(curs[i]), 4'd1);

        step("h10_wrap", B_UP, 32'h03b59b59, 5'd7, 4'd1);
        step("h10_up", B_UP, 32'h13b59b59, 5'd7, 4'd1);
        step("to_h1", B_RIGHT, 32'h13b59b59, 5'd6, 4'd1);
        for (int i = 0; i < 4; i++)
            step($sformatf("h1_down%0d", i), B_DN, hdn[i], 5'd6, 4'd1);
        step("to_h10", B_LEFT, 32'h19b59b59, 5'd7, 4'd1);
        step("h10_clamp", B_UP, 32'h23b59b59, 5'd7, 4'd1);
        step("to_h1_again", B_RIGHT, 32'h23b59b59, 5'd6, 4'd1);
        step("h1_wrap_at_20", B_UP, 32'h20b59b59, 5'd6, 4'd1);
        step("h1_down_at_20", B_DN, 32'h23b59b59, 5'd6, 4'd1);
        step("to_m10", B_RIGHT, 32'h23b59b59, 5'd4, 4'd1);
        step("m10_wrap", B_UP, 32'h23b09b59, 5'd4, 4'd1);

        expect_out("bounce", 32'h23b09b59, 5'd4, 4'd1);
        for (int i = 0; i < 5; i++) begin
            bus.btn_up = 1'b1;
            repeat (2) @(negedge clk);
            bus.btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check_out();
        chk("no_load_before_commit", 32'(load_cnt), 32'd0);

        drive(B_SET | B_UP);
        wait_commit(24'h230959);
        drive(5'd0);
        repeat (12) @(negedge clk);
        expect_out("back_to_run", 32'h01b02b03, 5'd31, 4'd0);
        check_out();
        chk("one_load", 32'(load_cnt), 32'd1);
        chk("set_time_hold", 32'(bus.set_time), 32'h230959);

        step("run_ignore_up", B_UP, 32'h01b02b03, 5'd31, 4'd0);
        step("run_ignore_left", B_LEFT, 32'h01b02b03, 5'd31, 4'd0);
        step("reenter_edit", B_SET, 32'h01b02b03, 5'd0, 4'd1);
        step("edit_up", B_UP, 32'h01b02b04, 5'd0, 4'd1);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("mid_edit_reset", 32'h00b00b00, 5'd31, 4'd0);
        check_out();
        chk("mid_reset.set_time", 32'(bus.set_time), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_out("after_reset", 32'h01b02b03, 5'd31, 4'd0);
        check_out();
        chk("no_load_on_abandon", 32'(load_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/time_set_editor.md
TIME_SET_EDITOR -- requirements
Module: time_set_editor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd1_000_000, meaning raw-button stable time in clk cycles before a press is accepted.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 24'd5_000_000, meaning held up/down auto-repeat period in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports btn_set, btn_left, btn_right, btn_up, btn_down  input  1 each  raw active-high push-buttons, asynchronous to clk.
REQ-006 SHALL have port cur_time  input  24  running time, BCD {h10,h1,m10,m1,s10,s1}.
REQ-007 SHALL have port digits  output  32  eight 4-bit display codes, [31:28]=position 7 ... [3:0]=position 0, for the downstream word/blink stage.
REQ-008 SHALL have port cursor  output  5  blinking digit position 0..7; 5'd31 = no blink.
REQ-009 SHALL have port mode  output  4  4'd0 run, 4'd1 edit.
REQ-010 SHALL have ports set_time  output  24  edited BCD time, and load  output  1  one-cycle commit strobe.

Function
REQ-011 Each button SHALL pass a 2-FF synchronizer, then a debouncer accepting a new level after DEBOUNCE_CYCLES consecutive equal samples; a rising edge of the debounced level yields one single-cycle press pulse.
REQ-012 Simultaneous press pulses SHALL be resolved by priority set > left > right > up > down; lower-priority pulses that cycle are dropped.
REQ-013 FSM states SHALL be RUN, EDIT, COMMIT; RUN-set -> EDIT (edit regs <= cur_time, cursor <= 0); EDIT-set -> COMMIT; COMMIT -> RUN unconditionally after one cycle.
REQ-014 digits layout SHALL be {h10,h1,4'hb,m10,m1,4'hb,s10,s1}; 4'hb = separator; source is cur_time in RUN, edit regs in EDIT/COMMIT; registered, 1-cycle latency.
REQ-015 Editable positions SHALL be 0,1,3,4,6,7; left increments position, right decrements, skipping 2 and 5, wrapping 7<->0.
REQ-016 up/down SHALL increment/decrement the cursor digit modulo its range: s10,m10 0..5; s1,m1 0..9; h10 0..2; h1 0..9, or 0..3 when h10=2.
REQ-017 When h10 becomes 2 with h1>3, h1 SHALL be clamped to 3 in the same cycle.
REQ-018 In COMMIT, load SHALL be 1 for exactly one cycle with set_time = edit regs; set_time SHALL hold that value until next COMMIT.
REQ-019 cursor SHALL be 5'd31 in RUN and COMMIT; mode SHALL be 4'd1 in EDIT and COMMIT, else 4'd0.
REQ-020 up/down/left/right pulses in RUN SHALL be ignored.

Reset
REQ-021 On rst_n low: state RUN, digits 32'h00b00b00, cursor 5'd31, mode 0, set_time 0, load 0, debouncers/counters cleared, edit regs 0.
REQ-022 Reset asserted mid-EDIT SHALL abandon the edit without a load pulse.

Configuration
REQ-023 With AUTO_REPEAT_EN defined, a debounced up/down held in EDIT SHALL issue an extra press pulse every REPEAT_CYCLES after the first; without it, only one pulse per press and no repeat counter is built.

Structure
REQ-024 Shared package SHALL hold state encodings, mode codes, separator code 4'hb, blank code 4'ha, cursor-off 5'd31, digit range limits.
REQ-025 Sub-module btn_debounce (synchronizer + debouncer + edge pulse), instantiated five times.

Verification
REQ-026 Reset, cur_time=24'h123456 -> digits 32'h12b34b56, cursor 31, mode 0.
REQ-027 set press with cur_time=24'h235959 -> mode 1, cursor 0; up -> digits[3:0] wraps 9->0; down -> 9.
REQ-028 cursor 0, left x3 -> 1,3,4; right x4 from 4 -> 3,1,0,7.
REQ-029 edit 19:xx:xx, cursor 7, up -> h10=2, h1 clamped to 3; up -> h10 wraps to 0.
REQ-030 set in EDIT -> load high one cycle, set_time = edit value, next cycle mode 0, cursor 31.
REQ-031 btn_up bounce pulses shorter than DEBOUNCE_CYCLES -> no increment; set and up same cycle -> only set acts.
